// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of per-processor read/write requests onto one 128-bit single-port memory
module mem_arbiter #(
   parameter int PROC_COUNT = 4,
   parameter int ADDR_W     = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [PROC_COUNT-1:0] i_req_rd,
   input  logic [PROC_COUNT-1:0] i_req_wr,
   input  logic [ADDR_W-1:0]     i_addr [PROC_COUNT],
   input  logic [127:0]          i_data [PROC_COUNT],
   input  logic [2:0]            i_wr_size [PROC_COUNT],
   output logic [PROC_COUNT-1:0] o_grant_rd,
   output logic [PROC_COUNT-1:0] o_grant_wr,
   output logic [PROC_COUNT-1:0] o_valid,
   output logic [127:0]          o_data,
   output logic                  o_busy,
   output logic                  o_mem_en,
   output logic                  o_mem_we,
   output logic [ADDR_W-1:0]     o_mem_addr,
   output logic [127:0]          o_mem_wdata,
   output logic [15:0]           o_mem_wstrb,
   input  logic [127:0]          i_mem_rdata,
   input  logic                  i_mem_rvalid
);
   localparam int IW = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_DONE} state_t;
   state_t                r_state;
   logic [IW-1:0]         r_ptr, r_idx;
   logic [PROC_COUNT-1:0] w_req, w_onehot, w_vld_oh;
   logic                  w_found, w_wr, w_size_ok;
   logic [IW-1:0]         w_idx;
   logic [2:0]            w_size;
   logic [15:0]           w_strb;
   assign w_req = i_req_rd | i_req_wr;
   // lowest requester at or above the pointer wins, else lowest below it
   always_comb begin
      w_idx = '0;
      for (int j = PROC_COUNT - 1; j >= 0; j--)
         if (w_req[j] && IW'(j) < r_ptr) w_idx = IW'(j);
      for (int j = PROC_COUNT - 1; j >= 0; j--)
         if (w_req[j] && IW'(j) >= r_ptr) w_idx = IW'(j);
   end
   assign w_found   = |w_req;
   assign w_wr      = i_req_wr[w_idx];
   assign w_size    = i_wr_size[w_idx];
   assign w_size_ok = (w_size != 3'd0) && (w_size <= 3'd4);
   assign w_strb    = (w_size == 3'd1) ? 16'h000F :
                      (w_size == 3'd2) ? 16'h00FF :
                      (w_size == 3'd3) ? 16'h0FFF : 16'hFFFF;
   assign w_onehot  = {{(PROC_COUNT-1){1'b0}}, 1'b1} << w_idx;
   assign w_vld_oh  = {{(PROC_COUNT-1){1'b0}}, 1'b1} << r_idx;
   assign o_busy    = (r_state != IDLE);
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_idx       <= '0;
         o_grant_rd  <= '0;
         o_grant_wr  <= '0;
         o_valid     <= '0;
         o_data      <= '0;
         o_mem_en    <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_wstrb <= '0;
      end else begin
         o_grant_rd <= '0;
         o_grant_wr <= '0;
         o_valid    <= '0;
         o_mem_en   <= 1'b0;
         case (r_state)
            IDLE: if (w_found) begin
               o_mem_we   <= w_wr;
               o_mem_addr <= i_addr[w_idx];
               r_idx      <= w_idx;
               r_ptr      <= (w_idx == IW'(PROC_COUNT - 1)) ? '0 : w_idx + 1'b1;
               if (w_wr) begin
                  o_grant_wr  <= w_onehot;
                  o_mem_en    <= w_size_ok;
                  o_mem_wdata <= i_data[w_idx];
                  o_mem_wstrb <= w_size_ok ? w_strb : 16'h0000;
                  r_state     <= WR_DONE;
               end else begin
                  o_grant_rd <= w_onehot;
                  o_mem_en   <= 1'b1;
                  r_state    <= RD_WAIT;
               end
            end
            RD_WAIT: if (i_mem_rvalid) begin
               o_data  <= i_mem_rdata;
               o_valid <= w_vld_oh;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
